counter_nbit_mod_updown: RTL and testbench

//  Parametrised N-bit up/down counter. Adds four things to a plain enable counter: a programmable

---
 rtl/counter_nbit_mod_updown_if.sv | 28 ++
 rtl/counter_nbit_mod_updown.sv | 87 ++++++++
 tb/tb_counter_nbit_mod_updown.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/counter_nbit_mod_updown_if.sv
// Control and status bundle for counter_nbit_mod_updown.
// The master drives the controls and reads back count, tc and ovf_sticky.
interface counter_nbit_mod_updown_if #(
  parameter int unsigned N  = 32,
  parameter int unsigned PW = 8
);
  logic          clr;
  logic          load;
  logic [N-1:0]  load_val;
  logic          count_enb;
  logic          up_dn;
  logic [N-1:0]  max_val;
  logic [PW-1:0] prescale;
  logic          ovf_clr;
  logic [N-1:0]  count;
  logic          tc;
  logic          ovf_sticky;

  modport master (
    output clr, load, load_val, count_enb, up_dn, max_val, prescale, ovf_clr,
    input  count, tc, ovf_sticky
  );

  modport slave (
    input  clr, load, load_val, count_enb, up_dn, max_val, prescale, ovf_clr,
    output count, tc, ovf_sticky
  );
endinterface

// File: rtl/counter_nbit_mod_updown.sv
// N-bit up/down counter with programmable modulus, wrap/saturate mode, parallel load,
// synchronous clear, enable prescaler, registered terminal-count pulse and sticky overflow.
module counter_nbit_mod_updown #(
  parameter int unsigned N        = 32,
  parameter int unsigned PW       = 8,
  parameter bit          SAT_MODE = 1'b0
) (
  input logic                    clk,
  input logic                    reset,
  counter_nbit_mod_updown_if.slave bus
);

  logic [N-1:0]  count_q, count_d;
  logic [PW-1:0] pcnt_q, pcnt_d;
  logic          tc_q, tc_d;
  logic          ovf_q, ovf_d;
  logic          step;
  logic          boundary;

  always_comb begin
    count_d  = count_q;
    pcnt_d   = pcnt_q;
    tc_d     = 1'b0;
    ovf_d    = ovf_q & ~bus.ovf_clr;
    step     = 1'b0;
    boundary = 1'b0;

    if (bus.clr) begin
      count_d = '0;
      pcnt_d  = '0;
    end else if (bus.load) begin
      count_d = bus.load_val;
      pcnt_d  = '0;
    end else if (bus.count_enb) begin
      // A prescale lowered below pcnt lets pcnt roll over through 2^PW rather than stall.
      if (pcnt_q == bus.prescale) begin
        step   = 1'b1;
        pcnt_d = '0;
      end else begin
        pcnt_d = pcnt_q + 1'b1;
      end
    end

    if (step) begin
      if (bus.up_dn) begin
        if (count_q < bus.max_val) begin
          count_d = count_q + 1'b1;
        end else begin
          boundary = 1'b1;
          count_d  = SAT_MODE ? bus.max_val : '0;
        end
      end else begin
        if (count_q != '0) begin
          count_d = count_q - 1'b1;
        end else begin
          boundary = 1'b1;
          count_d  = SAT_MODE ? '0 : bus.max_val;
        end
      end
    end

    // A boundary step outranks ovf_clr in the same cycle.
    if (boundary) begin
      tc_d  = 1'b1;
      ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
      pcnt_q  <= '0;
      tc_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      pcnt_q  <= pcnt_d;
      tc_q    <= tc_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.count      = count_q;
  assign bus.tc         = tc_q;
  assign bus.ovf_sticky = ovf_q;

endmodule

// File: tb/tb_counter_nbit_mod_updown.sv
// Directed bench: a wrapping and a saturating instance driven with identical stimulus.
module tb_counter_nbit_mod_updown;

  logic clk;
  logic reset;
  int   passed;
  int   total;

  counter_nbit_mod_updown_if #(.N(8), .PW(4)) bw ();
  counter_nbit_mod_updown_if #(.N(8), .PW(4)) bs ();

  counter_nbit_mod_updown #(.N(8), .PW(4), .SAT_MODE(1'b0)) dut_wrap (
    .clk   (clk),
    .reset (reset),
    .bus   (bw)
  );

  counter_nbit_mod_updown #(.N(8), .PW(4), .SAT_MODE(1'b1)) dut_sat (
    .clk   (clk),
    .reset (reset),
    .bus   (bs)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: actual=running required=finished");
    $fatal(1, "timeout");
  end

  task automatic drive(input logic c, input logic l, input logic [7:0] lv, input logic e,
                       input logic u, input logic [7:0] mx, input logic [3:0] ps,
                       input logic oc);
    bw.clr = c; bw.load = l; bw.load_val = lv; bw.count_enb = e;
    bw.up_dn = u; bw.max_val = mx; bw.prescale = ps; bw.ovf_clr = oc;
    bs.clr = c; bs.load = l; bs.load_val = lv; bs.count_enb = e;
    bs.up_dn = u; bs.max_val = mx; bs.prescale = ps; bs.ovf_clr = oc;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    drive(1'b0, 1'b0, 8'd0, 1'b0, 1'b1, 8'd0, 4'd0, 1'b0);
    reset = 1'b0;
    #22;
    total++;
    if (bw.count !== 8'd0 || bw.tc !== 1'b0 || bw.ovf_sticky !== 1'b0)
      $display("FAIL reset_wrap: actual=%0d/%b/%b required=0/0/0", bw.count, bw.tc, bw.ovf_sticky);
    else passed++;
    total++;
    if (bs.count !== 8'd0 || bs.tc !== 1'b0 || bs.ovf_sticky !== 1'b0)
      $display("FAIL reset_sat: actual=%0d/%b/%b required=0/0/0", bs.count, bs.tc, bs.ovf_sticky);
    else passed++;
    tick();
    reset = 1'b1;
  endtask

  task automatic test_up_wrap_sat();
    logic [7:0] exp_w [8] = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd0, 8'd1, 8'd2};
    logic [7:0] exp_s [8] = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd5, 8'd5, 8'd5};
    logic       tcw, tcs;
    drive(1'b0, 1'b0, 8'd0, 1'b1, 1'b1, 8'd5, 4'd0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      tick();
      tcw = (i == 5);
      tcs = (i >= 5);
      total++;
      if (bw.count !== exp_w[i] || bw.tc !== tcw)
        $display("FAIL up_wrap clk%0d: actual=%0d tc=%b required=%0d tc=%b",
                 i + 1, bw.count, bw.tc, exp_w[i], tcw);
      else passed++;
      total++;
      if (bs.count !== exp_s[i] || bs.tc !== tcs)
        $display("FAIL up_sat clk%0d: actual=%0d tc=%b required=%0d tc=%b",
                 i + 1, bs.count, bs.tc, exp_s[i], tcs);
      else passed++;
    end
    total++;
    if (bw.ovf_sticky !== 1'b1 || bs.ovf_sticky !== 1'b1)
      $display("FAIL up_ovf: actual=%b/%b required=1/1", bw.ovf_sticky, bs.ovf_sticky);
    else passed++;
  endtask

  task automatic test_down_prescale();
    logic [7:0] exp_w [9] = '{8'd2, 8'd2, 8'd1, 8'd1, 8'd1, 8'd0, 8'd0, 8'd0, 8'd9};
    logic [7:0] exp_s [9] = '{8'd2, 8'd2, 8'd1, 8'd1, 8'd1, 8'd0, 8'd0, 8'd0, 8'd0};
    logic       tce;
    drive(1'b0, 1'b1, 8'd2, 1'b1, 1'b0, 8'd9, 4'd2, 1'b0);
    tick();
    total++;
    if (bw.count !== 8'd2 || bs.count !== 8'd2 || bw.tc !== 1'b0)
      $display("FAIL load2: actual=%0d/%0d tc=%b required=2/2 tc=0", bw.count, bs.count, bw.tc);
    else passed++;
    drive(1'b0, 1'b0, 8'd2, 1'b1, 1'b0, 8'd9, 4'd2, 1'b0);
    for (int i = 0; i < 9; i++) begin
      tick();
      tce = (i == 8);
      total++;
      if (bw.count !== exp_w[i] || bw.tc !== tce)
        $display("FAIL down_wrap clk%0d: actual=%0d tc=%b required=%0d tc=%b",
                 i + 1, bw.count, bw.tc, exp_w[i], tce);
      else passed++;
      total++;
      if (bs.count !== exp_s[i] || bs.tc !== tce)
        $display("FAIL down_sat clk%0d: actual=%0d tc=%b required=%0d tc=%b",
                 i + 1, bs.count, bs.tc, exp_s[i], tce);
      else passed++;
    end
  endtask

  task automatic test_load_above_max();
    drive(1'b0, 1'b1, 8'd200, 1'b1, 1'b1, 8'd100, 4'd0, 1'b0);
    tick();
    total++;
    if (bw.count !== 8'd200 || bs.count !== 8'd200)
      $display("FAIL load200: actual=%0d/%0d required=200/200", bw.count, bs.count);
    else passed++;
    drive(1'b0, 1'b0, 8'd200, 1'b1, 1'b1, 8'd100, 4'd0, 1'b0);
    tick();
    total++;
    if (bw.count !== 8'd0 || bw.tc !== 1'b1)
      $display("FAIL above_max_wrap: actual=%0d tc=%b required=0 tc=1", bw.count, bw.tc);
    else passed++;
    total++;
    if (bs.count !== 8'd100 || bs.tc !== 1'b1)
      $display("FAIL above_max_sat: actual=%0d tc=%b required=100 tc=1", bs.count, bs.tc);
    else passed++;
  endtask

  task automatic test_clr_and_ovf();
    logic [7:0] exp_c [3] = '{8'd0, 8'd0, 8'd1};
    drive(1'b1, 1'b1, 8'd50, 1'b1, 1'b1, 8'd100, 4'd2, 1'b0);
    tick();
    total++;
    if (bw.count !== 8'd0 || bs.count !== 8'd0 || bw.tc !== 1'b0 || bs.tc !== 1'b0)
      $display("FAIL clr_load: actual=%0d/%0d tc=%b/%b required=0/0 tc=0/0",
               bw.count, bs.count, bw.tc, bs.tc);
    else passed++;
    drive(1'b0, 1'b0, 8'd50, 1'b1, 1'b1, 8'd100, 4'd2, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if (bw.count !== exp_c[i])
        $display("FAIL clr_pcnt clk%0d: actual=%0d required=%0d", i + 1, bw.count, exp_c[i]);
      else passed++;
    end
    drive(1'b0, 1'b0, 8'd0, 1'b0, 1'b1, 8'd100, 4'd0, 1'b1);
    tick();
    total++;
    if (bw.ovf_sticky !== 1'b0 || bs.ovf_sticky !== 1'b0)
      $display("FAIL ovf_clr: actual=%b/%b required=0/0", bw.ovf_sticky, bs.ovf_sticky);
    else passed++;
    drive(1'b1, 1'b0, 8'd0, 1'b1, 1'b1, 8'd0, 4'd0, 1'b1);
    tick();
    drive(1'b0, 1'b0, 8'd0, 1'b1, 1'b1, 8'd0, 4'd0, 1'b1);
    tick();
    total++;
    if (bw.count !== 8'd0 || bw.tc !== 1'b1 || bw.ovf_sticky !== 1'b1)
      $display("FAIL ovf_race_up: actual=%0d/%b/%b required=0/1/1",
               bw.count, bw.tc, bw.ovf_sticky);
    else passed++;
    drive(1'b0, 1'b0, 8'd0, 1'b1, 1'b0, 8'd0, 4'd0, 1'b1);
    tick();
    total++;
    if (bs.count !== 8'd0 || bs.tc !== 1'b1 || bs.ovf_sticky !== 1'b1)
      $display("FAIL ovf_race_down: actual=%0d/%b/%b required=0/1/1",
               bs.count, bs.tc, bs.ovf_sticky);
    else passed++;
    drive(1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 8'd0, 4'd0, 1'b1);
    tick();
    total++;
    if (bw.ovf_sticky !== 1'b0 || bw.tc !== 1'b0)
      $display("FAIL ovf_release: actual=%b tc=%b required=0 tc=0", bw.ovf_sticky, bw.tc);
    else passed++;
  endtask

  task automatic test_async_reset();
    drive(1'b1, 1'b0, 8'd0, 1'b1, 1'b1, 8'd9, 4'd1, 1'b0);
    tick();
    drive(1'b0, 1'b0, 8'd0, 1'b1, 1'b1, 8'd9, 4'd1, 1'b0);
    for (int i = 0; i < 7; i++) tick();
    total++;
    if (bw.count !== 8'd3)
      $display("FAIL pre_reset: actual=%0d required=3", bw.count);
    else passed++;
    #1;
    reset = 1'b0;
    #1;
    total++;
    if (bw.count !== 8'd0 || bs.count !== 8'd0 || bw.tc !== 1'b0 || bw.ovf_sticky !== 1'b0)
      $display("FAIL async_reset: actual=%0d/%0d/%b/%b required=0/0/0/0",
               bw.count, bs.count, bw.tc, bw.ovf_sticky);
    else passed++;
    #1;
    reset = 1'b1;
    tick();
    total++;
    if (bw.count !== 8'd0)
      $display("FAIL post_reset_clk1: actual=%0d required=0", bw.count);
    else passed++;
    tick();
    total++;
    if (bw.count !== 8'd1 || bs.count !== 8'd1)
      $display("FAIL post_reset_clk2: actual=%0d/%0d required=1/1", bw.count, bs.count);
    else passed++;
  endtask

  initial begin
    passed = 0;
    total  = 0;
    reset  = 1'b1;
    test_reset();
    test_up_wrap_sat();
    test_down_prescale();
    test_load_above_max();
    test_clr_and_ovf();
    test_async_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
